// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR writeback arbiter.
package gpr_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 5;
  localparam int unsigned NGPR = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [63:0] COMMIT_CNT_RST = 64'd0;

endpackage

// File: rtl/gpr_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr wins.
module gpr_wb_arbiter_rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [PW-1:0]   winner_c
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  // Walk the requesters from ptr, wrapping once past NREQ-1.
  always_comb begin
    logic [PW:0] idx;
    logic        found;
    grant_c  = '0;
    winner_c = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (!found && valid[idx[PW-1:0]]) begin
        found                 = 1'b1;
        grant_c[idx[PW-1:0]]  = 1'b1;
        winner_c              = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter sharing the GPR write port, with a freeze/ack handshake
// that quiesces the register file for external snapshots.
module gpr_wb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 freeze_req,
  output logic                 freeze_ack,
  output logic [63:0]          commit_cnt
);

  import gpr_pkg::*;

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              rf_wen_q, rf_wen_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              freeze_ack_q, freeze_ack_d;
  logic [63:0]       commit_cnt_q, commit_cnt_d;

  logic [NREQ-1:0]   grant_c;
  logic [PW-1:0]     winner_c;
  logic              arb_en_c;
  logic              transfer_c;
  logic [AW-1:0]     win_addr_c;
  logic [XLEN-1:0]   win_data_c;

  gpr_wb_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .valid    (req_valid),
    .ptr      (ptr_q),
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  // Grants only in RUN with no freeze pending; a freeze request wins same-cycle.
  assign arb_en_c   = !reset && (state_q == RUN) && !freeze_req;
  assign req_ready  = arb_en_c ? grant_c : '0;
  assign transfer_c = |req_ready;

  always_comb begin
    win_addr_c = '0;
    win_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner_c == PW'(i)) begin
        win_addr_c = req_addr[i*AW +: AW];
        win_data_c = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    commit_cnt_d = commit_cnt_q;

    // x0 writes are accepted and counted but never reach the regfile.
    if (transfer_c) begin
      ptr_d        = (winner_c == PW'(NREQ-1)) ? '0 : winner_c + PW'(1);
      rf_wen_d     = (win_addr_c != '0);
      rf_waddr_d   = win_addr_c;
      rf_wdata_d   = win_data_c;
      commit_cnt_d = commit_cnt_q + 64'd1;
    end

    unique case (state_q)
      RUN:     if (freeze_req) state_d = DRAIN;
      DRAIN:   state_d = FROZEN;
      FROZEN:  if (!freeze_req) state_d = RUN;
      default: state_d = RUN;
    endcase

    freeze_ack_d = (state_d == FROZEN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      freeze_ack_q <= 1'b0;
      commit_cnt_q <= COMMIT_CNT_RST;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      freeze_ack_q <= freeze_ack_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign freeze_ack = freeze_ack_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: cycle model + expected-write scoreboard,
// plus a three-requester instance for fairness.
module tb_gpr_wb_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Two-requester instance
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [9:0]   req_addr;
  logic [127:0] req_data;
  logic         rf_wen;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic         freeze_req;
  logic         freeze_ack;
  logic [63:0]  commit_cnt;

  gpr_wb_arbiter #(.NREQ(2), .XLEN(64), .AW(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .freeze_req (freeze_req),
    .freeze_ack (freeze_ack),
    .commit_cnt (commit_cnt)
  );

  // Three-requester instance
  logic [2:0]   b_valid;
  logic [2:0]   b_ready;
  logic [14:0]  b_addr;
  logic [191:0] b_data;
  logic         b_wen;
  logic [4:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic         b_freeze_req;
  logic         b_freeze_ack;
  logic [63:0]  b_commit_cnt;

  gpr_wb_arbiter #(.NREQ(3), .XLEN(64), .AW(5)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (b_valid),
    .req_ready  (b_ready),
    .req_addr   (b_addr),
    .req_data   (b_data),
    .rf_wen     (b_wen),
    .rf_waddr   (b_waddr),
    .rf_wdata   (b_wdata),
    .freeze_req (b_freeze_req),
    .freeze_ack (b_freeze_ack),
    .commit_cnt (b_commit_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: 0=RUN 1=DRAIN 2=FROZEN
  int          m_state;
  int          m_ptr;
  logic [63:0] m_cnt;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  logic        m_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m_cnt   = '0;
    m_waddr = '0;
    m_wdata = '0;
    m_ack   = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    req_valid    = '0;
    req_addr     = '0;
    req_data     = '0;
    freeze_req   = 1'b0;
    b_valid      = '0;
    b_addr       = '0;
    b_data       = '0;
    b_freeze_req = 1'b0;
    repeat (2) @(negedge clock);
    req_valid = 2'b11;
    #1;
    chk("rst_ready",  64'(req_ready), 64'd0);
    chk("rst_wen",    64'(rf_wen), 64'd0);
    chk("rst_waddr",  64'(rf_waddr), 64'd0);
    chk("rst_wdata",  rf_wdata, 64'd0);
    chk("rst_ack",    64'(freeze_ack), 64'd0);
    chk("rst_cnt",    commit_cnt, 64'd0);
    req_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus on the two-requester DUT, checked against the model.
  task automatic cycle(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1, input logic frz,
                       output logic [1:0] g);
    logic [1:0] eg;
    int         w;
    exp_t       e;
    @(negedge clock);
    req_valid  = v;
    req_addr   = {a1, a0};
    req_data   = {d1, d0};
    freeze_req = frz;
    #1;
    eg = '0;
    w  = 0;
    if (m_state == 0 && !frz) begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (m_ptr + k) % 2;
        if (v[idx] && eg == 2'b00) begin
          eg[idx] = 1'b1;
          w       = idx;
        end
      end
    end
    chk("ready", 64'(req_ready), 64'(eg));
    g = req_ready;
    if (eg != 2'b00) begin
      m_waddr = (w == 0) ? a0 : a1;
      m_wdata = (w == 0) ? d0 : d1;
      e.wen   = (m_waddr != 5'd0);
      m_cnt   = m_cnt + 64'd1;
      m_ptr   = (w + 1) % 2;
    end else begin
      e.wen = 1'b0;
    end
    e.addr = m_waddr;
    e.data = m_wdata;
    exp_q.push_back(e);
    case (m_state)
      0: if (frz) m_state = 1;
      1: m_state = 2;
      default: if (!frz) m_state = 0;
    endcase
    m_ack = (m_state == 2);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("wen",   64'(rf_wen), 64'(e.wen));
    chk("waddr", 64'(rf_waddr), 64'(e.addr));
    chk("wdata", rf_wdata, e.data);
    chk("cnt",   commit_cnt, m_cnt);
    chk("ack",   64'(freeze_ack), 64'(m_ack));
  endtask

  initial begin
    logic [1:0] g;
    int         cnt3 [3];
    int         widx;

    // Single requester
    do_reset();
    cycle(2'b01, 5'd5, 64'hDEAD, 5'd0, 64'd0, 1'b0, g);
    chk("single_grant", 64'(g), 64'h1);
    chk("single_wen",   64'(rf_wen), 64'd1);
    chk("single_addr",  64'(rf_waddr), 64'd5);
    chk("single_data",  rf_wdata, 64'hDEAD);
    chk("single_cnt",   commit_cnt, 64'd1);
    cycle(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, g);

    // Contention: grants alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 5'd1, 64'h100 + 64'(i), 5'd2, 64'h200 + 64'(i), 1'b0, g);
      chk("cont_grant", 64'(g), (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("cont_addr",  64'(rf_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    chk("cont_cnt", commit_cnt, 64'd4);

    // x0 write: accepted and counted, no regfile write
    do_reset();
    cycle(2'b10, 5'd0, 64'd0, 5'd0, 64'hFF, 1'b0, g);
    chk("x0_grant", 64'(g), 64'h2);
    chk("x0_wen",   64'(rf_wen), 64'd0);
    chk("x0_cnt",   commit_cnt, 64'd1);
    chk("x0_data",  rf_wdata, 64'hFF);

    // Freeze while busy
    do_reset();
    cycle(2'b01, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b0, g);  // t
    chk("frz_t_grant", 64'(g), 64'h1);
    chk("frz_t1_wen",  64'(rf_wen), 64'd1);
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b1, g);  // t+1
    chk("frz_t1_grant", 64'(g), 64'h0);
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b1, g);  // t+2
    chk("frz_t2_grant", 64'(g), 64'h0);
    chk("frz_t3_ack",   64'(freeze_ack), 64'd1);
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b1, g);  // t+3
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b1, g);  // t+4
    chk("frz_t4_grant", 64'(g), 64'h0);
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b0, g);  // t+5
    chk("frz_t5_grant", 64'(g), 64'h0);
    chk("frz_t6_ack",   64'(freeze_ack), 64'd0);
    cycle(2'b10, 5'd3, 64'hA1, 5'd4, 64'hB2, 1'b0, g);  // t+6
    chk("frz_t6_grant", 64'(g), 64'h2);
    chk("frz_t7_addr",  64'(rf_waddr), 64'd4);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(2'b01, 5'd7, 64'h70 + 64'(i), 5'd0, 64'd0, 1'b0, g);
    end
    chk("pre_rst_wen", 64'(rf_wen), 64'd1);
    chk("pre_rst_cnt", commit_cnt, 64'd7);
    #2;
    reset = 1'b1;
    #1;
    chk("async_wen",   64'(rf_wen), 64'd0);
    chk("async_cnt",   commit_cnt, 64'd0);
    chk("async_ack",   64'(freeze_ack), 64'd0);
    chk("async_waddr", 64'(rf_waddr), 64'd0);
    chk("async_ready", 64'(req_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    req_valid = '0;

    // Fairness with three requesters
    do_reset();
    b_addr = {5'd13, 5'd12, 5'd11};
    b_data = {64'h3333, 64'h2222, 64'h1111};
    for (int i = 0; i < 3; i++) cnt3[i] = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      b_valid = 3'b111;
      #1;
      chk("fair_grant", 64'(b_ready), 64'(1) << (i % 3));
      widx = -1;
      for (int k = 0; k < 3; k++) if (b_ready[k]) widx = k;
      if (widx >= 0) cnt3[widx]++;
    end
    @(negedge clock);
    b_valid = '0;
    #1;
    for (int k = 0; k < 3; k++) chk("fair_count", 64'(cnt3[k]), 64'd3);
    chk("fair_cnt", b_commit_cnt, 64'd9);
    chk("fair_last_addr", 64'(b_waddr), 64'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
